button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//  Front end between the five raw watch push-buttons and the watch mode/set state machine.
//  Per button:
//   - synchronises the raw level (2 flops);
//   - debounces it;
//   - emits a single-cycle press pulse, which the state machine consumes directly.
//  btn_increment/btn_decrement also auto-repeat while held, when repeat_en=1.
//  The state machine drives repeat_en high in its hour/minute set states.
// PARAMETERS
//  DEBOUNCE_CYCLES  16   consecutive cycles a synced level must differ from the stable level before it is accepted (>=2)
//  REPEAT_DELAY     500  cycles from the initial press pulse to the first repeat pulse (>=2)
//  REPEAT_PERIOD    125  cycles between successive repeat pulses (>=2)
//  CNT_W            10   width of debounce/repeat counters; must hold max(DEBOUNCE_CYCLES,REPEAT_DELAY,REPEAT_PERIOD)
// PORTS
//  clk                 in   1  system clock; all state on rising edge
//  reset_n             in   1  asynchronous reset, active-low
//  btn_mode_raw        in   1  raw mode button; async, bouncy, 1=pressed
//  btn_time_set_raw    in   1  raw time-set button
//  btn_increment_raw   in   1  raw increment button
//  btn_decrement_raw   in   1  raw decrement button
//  btn_backlight_raw   in   1  raw backlight button
//  repeat_en           in   1  1 = auto-repeat allowed on increment/decrement
//  btn_mode            out  1  one-cycle press pulse
//  btn_time_set        out  1  one-cycle press pulse
//  btn_increment       out  1  press pulse plus repeat pulses
//  btn_decrement       out  1  press pulse plus repeat pulses
//  btn_backlight       out  1  one-cycle press pulse
//  backlight_held      out  1  debounced stable level of the backlight button
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - sync flops, stable levels, counters and all outputs clear to 0 immediately.
//   - On release, a button already held is treated as a new press: pulse after the full debounce latency.
//  Channel pipeline: raw -> s1 -> s2 -> stable.
//   - cnt increments each edge while s2!=stable; it clears to 0 on any edge where s2==stable.
//   - When s2!=stable and cnt==DEBOUNCE_CYCLES-1, stable<=s2 and cnt<=0.
//  Latency: raw first sampled high at edge E0 with no bounce -> stable rises at edge E0+DEBOUNCE_CYCLES+1.
//  Press pulse:
//   - Registered. Output is 1 for exactly the one cycle after the edge where stable goes 0->1.
//   - Release (1->0) produces no pulse.
//  Per-channel state (increment/decrement only): IDLE -> HELD_WAIT -> HELD_REPEAT.
//   - IDLE: stable=0. When stable rises: emit press pulse, load rcnt=0, go to HELD_WAIT if repeat_en, else stay IDLE.
//   - HELD_WAIT: rcnt counts up each cycle. At rcnt==REPEAT_DELAY-1: emit pulse, rcnt=0, go to HELD_REPEAT.
//   - HELD_REPEAT: at rcnt==REPEAT_PERIOD-1, emit pulse and set rcnt=0.
//   - Any state, stable falls or repeat_en=0: rcnt=0, go to IDLE; no pulse that cycle.
//   - repeat_en rises while stable=1 and in IDLE: enter HELD_WAIT with rcnt=0.
//  Timing: press pulse at cycle P -> first repeat at P+REPEAT_DELAY, then every REPEAT_PERIOD.
//  Inc/dec conflict:
//   - If increment and decrement would both pulse in the same cycle, both outputs stay 0.
//   - While both stable levels are 1, all repeat pulses on both are suppressed; counters keep running.
//  Other channels: mode, time_set and backlight never repeat and are independent of each other.
//   - Simultaneous pulses on different channels are all passed through.
//  At most one pulse per channel per cycle. Outputs are glitch-free flop outputs.
//  Counters never wrap: they hold at their terminal compare and reset there.
// TESTING (DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3, raw changes just after edge)
//  1 clean press: inc_raw=1 from E0 for 30 cycles, repeat_en=0 -> btn_increment=1 only in the cycle after E5; no further pulses.
//  2 bounce/glitch:
//     - mode_raw 1,0,1,0,1,0 per cycle, then steady 1 -> exactly one btn_mode pulse, 5 edges after steady start.
//     - A 3-cycle high glitch -> no pulse.
//  3 auto-repeat: repeat_en=1, dec_raw held 30 cycles -> btn_decrement pulses at P, P+8, P+11, P+14, ...
//     - Stops within 1 cycle of stable falling.
//  4 repeat_en drop: as 3, but repeat_en=0 at P+9 -> no pulse at P+11; re-enable at P+12 -> next pulse P+20.
//  5 conflict: inc_raw and dec_raw rise on the same edge, repeat_en=1 -> no pulses on either output for the whole hold.
//  6 reset mid-hold: inc held, reset_n=0 at P+5 -> all outputs 0 at once; reset_n=1 with inc still held -> new press pulse 6 edges later.

Source files
------------

// File: rtl/button_conditioner.sv
// Five-channel push-button front end: 2-flop sync, counter debounce, single-cycle press pulses,
// plus auto-repeat on increment/decrement with inc/dec conflict suppression.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_DELAY    = 500,
  parameter int REPEAT_PERIOD   = 125,
  parameter int CNT_W           = 10
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_mode_raw,
  input  logic btn_time_set_raw,
  input  logic btn_increment_raw,
  input  logic btn_decrement_raw,
  input  logic btn_backlight_raw,
  input  logic repeat_en,
  output logic btn_mode,
  output logic btn_time_set,
  output logic btn_increment,
  output logic btn_decrement,
  output logic btn_backlight,
  output logic backlight_held
);

  localparam int NCH = 5;
  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    HELD_WAIT   = 2'd1,
    HELD_REPEAT = 2'd2
  } rep_state_t;

  // Channel order: 0 mode, 1 time_set, 2 increment, 3 decrement, 4 backlight
  logic [NCH-1:0] raw;
  logic [NCH-1:0] stable;
  logic [NCH-1:0] stable_next;
  logic [NCH-1:0] rise;
  logic [1:0]     rep_evt;
  logic [NCH-1:0] pulse_reg;
  logic [NCH-1:0] pulse_next;

  assign raw = {btn_backlight_raw, btn_decrement_raw, btn_increment_raw,
                btn_time_set_raw, btn_mode_raw};

  for (genvar gi = 0; gi < NCH; gi++) begin : g_db
    logic             s1_reg;
    logic             s2_reg;
    logic             stable_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             differ;

    assign differ          = s2_reg ^ stable_reg;
    assign stable_next[gi] = (differ && cnt_reg == DB_LAST) ? s2_reg : stable_reg;
    assign stable[gi]      = stable_reg;
    assign rise[gi]        = stable_next[gi] & ~stable_reg;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        s1_reg     <= 1'b0;
        s2_reg     <= 1'b0;
        stable_reg <= 1'b0;
        cnt_reg    <= '0;
      end else begin
        s1_reg     <= raw[gi];
        s2_reg     <= s1_reg;
        stable_reg <= stable_next[gi];
        // Clears both on agreement and on acceptance, so the counter never wraps
        if (!differ || cnt_reg == DB_LAST)
          cnt_reg <= '0;
        else
          cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rep
    localparam int CH = gi + 2;
    rep_state_t       state_reg;
    rep_state_t       state_next;
    logic [CNT_W-1:0] rcnt_reg;
    logic [CNT_W-1:0] rcnt_next;
    logic             rep_pulse;

    assign rep_evt[gi] = rep_pulse;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg <= IDLE;
        rcnt_reg  <= '0;
      end else begin
        state_reg <= state_next;
        rcnt_reg  <= rcnt_next;
      end
    end

    // A held button with repeat enabled (fresh press or late enable) arms the delay
    always_comb begin
      state_next = state_reg;
      rcnt_next  = rcnt_reg;
      rep_pulse  = 1'b0;
      case (state_reg)
        IDLE: begin
          rcnt_next = '0;
          if (stable_next[CH] && repeat_en)
            state_next = HELD_WAIT;
        end
        HELD_WAIT: begin
          if (!stable_next[CH] || !repeat_en) begin
            state_next = IDLE;
            rcnt_next  = '0;
          end else if (rcnt_reg == RD_LAST) begin
            rep_pulse  = 1'b1;
            rcnt_next  = '0;
            state_next = HELD_REPEAT;
          end else begin
            rcnt_next = rcnt_reg + 1'b1;
          end
        end
        HELD_REPEAT: begin
          if (!stable_next[CH] || !repeat_en) begin
            state_next = IDLE;
            rcnt_next  = '0;
          end else if (rcnt_reg == RP_LAST) begin
            rep_pulse = 1'b1;
            rcnt_next = '0;
          end else begin
            rcnt_next = rcnt_reg + 1'b1;
          end
        end
        default: begin
          state_next = IDLE;
          rcnt_next  = '0;
        end
      endcase
    end
  end

  logic both_held;
  logic inc_fire;
  logic dec_fire;

  // Repeats are muted while both are held; coincident pulses cancel each other
  assign both_held = stable[2] & stable[3];
  assign inc_fire  = rise[2] | (rep_evt[0] & ~both_held);
  assign dec_fire  = rise[3] | (rep_evt[1] & ~both_held);

  assign pulse_next = {rise[4], dec_fire & ~inc_fire, inc_fire & ~dec_fire, rise[1], rise[0]};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      pulse_reg <= '0;
    else
      pulse_reg <= pulse_next;
  end

  assign btn_mode       = pulse_reg[0];
  assign btn_time_set   = pulse_reg[1];
  assign btn_increment  = pulse_reg[2];
  assign btn_decrement  = pulse_reg[3];
  assign btn_backlight  = pulse_reg[4];
  assign backlight_held = stable[4];

endmodule
